// File: rtl/ps2_key_event.sv
// PS/2 scan-byte decoder: turns make/break/E0 sequences into key events with a held-key table and event FIFO.
// Latency: event pushed on the edge consuming the last byte; input never backpressured, FIFO drops on full.
module ps2_ev_fifo #(
  parameter int W     = 10,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         clrn,
  input  logic         push,
  input  logic [W-1:0] push_dat,
  input  logic         pop,
  output logic         vld,
  output logic         drop,
  output logic [W-1:0] head
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   cnt;
  logic          full, do_pop, do_push;

  assign full    = (cnt == (AW+1)'(DEPTH));
  assign vld     = (cnt != '0);
  assign do_pop  = pop && vld;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);
  assign drop    = push && !do_push;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_dat;
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + (AW+1)'(1);
        2'b01:   cnt <= cnt - (AW+1)'(1);
        default: cnt <= cnt;
      endcase
    end
  end
endmodule

module ps2_key_event #(
  parameter int CNT_W      = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int MAX_KEYS   = 4
) (
  input  logic                          clk,
  input  logic                          clrn,
  input  logic                          in_valid,
  input  logic [7:0]                    in_code,
  output logic                          ev_valid,
  input  logic                          ev_ready,
  output logic [7:0]                    ev_code,
  output logic                          ev_ext,
  output logic                          ev_break,
  output logic [CNT_W-1:0]              key_count,
  output logic [$clog2(MAX_KEYS+1)-1:0] held_num,
  output logic                          any_held,
  output logic                          overflow,
  output logic                          proto_err,
  input  logic                          clr_flags
);
  localparam int HW = $clog2(MAX_KEYS+1);
  localparam int IW = (MAX_KEYS > 1) ? $clog2(MAX_KEYS) : 1;

  typedef enum logic [1:0] {IDLE, EXT, BRK, EXT_BRK} state_t;

  state_t        state, nxt;
  logic          fire_make, fire_brk, is_ext, perr;
  logic [8:0]    key;
  logic          tbl_vld [MAX_KEYS];
  logic [8:0]    tbl_key [MAX_KEYS];
  logic [MAX_KEYS-1:0] hit_vec;
  logic          hit, free_found;
  logic [IW-1:0] free_idx;
  logic          push, drop;
  logic [9:0]    head;

  always_comb begin
    nxt       = state;
    fire_make = 1'b0;
    fire_brk  = 1'b0;
    is_ext    = 1'b0;
    perr      = 1'b0;
    if (in_valid) begin
      if (in_code == 8'h00 || in_code == 8'hFF || in_code == 8'hE1) begin
        nxt = IDLE;
      end else begin
        case (state)
          IDLE: begin
            if (in_code == 8'hE0)      nxt = EXT;
            else if (in_code == 8'hF0) nxt = BRK;
            else                       fire_make = 1'b1;
          end
          EXT: begin
            nxt = IDLE;
            if (in_code == 8'hE0)      perr = 1'b1;
            else if (in_code == 8'hF0) nxt = EXT_BRK;
            else begin
              fire_make = 1'b1;
              is_ext    = 1'b1;
            end
          end
          default: begin
            nxt    = IDLE;
            is_ext = (state == EXT_BRK);
            if (in_code == 8'hE0 || in_code == 8'hF0) perr = 1'b1;
            else                                      fire_brk = 1'b1;
          end
        endcase
      end
    end
  end

  assign key = {is_ext, in_code};

  always_comb begin
    hit_vec    = '0;
    free_found = 1'b0;
    free_idx   = '0;
    for (int i = MAX_KEYS-1; i >= 0; i--) begin
      hit_vec[i] = tbl_vld[i] && (tbl_key[i] == key);
      if (!tbl_vld[i]) begin
        free_found = 1'b1;
        free_idx   = IW'(i);
      end
    end
  end

  assign hit  = |hit_vec;
  // Typematic repeats of a held key are swallowed; breaks always report.
  assign push = fire_brk || (fire_make && !hit);

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state     <= IDLE;
      key_count <= '0;
      held_num  <= '0;
      overflow  <= 1'b0;
      proto_err <= 1'b0;
      for (int i = 0; i < MAX_KEYS; i++) begin
        tbl_vld[i] <= 1'b0;
        tbl_key[i] <= '0;
      end
    end else begin
      state     <= nxt;
      overflow  <= (overflow && !clr_flags) || drop;
      proto_err <= (proto_err && !clr_flags) || perr;
      if (fire_make && !hit) begin
        key_count <= key_count + CNT_W'(1);
        if (free_found) begin
          tbl_vld[free_idx] <= 1'b1;
          tbl_key[free_idx] <= key;
          held_num          <= held_num + HW'(1);
        end
      end
      if (fire_brk && hit) begin
        for (int i = 0; i < MAX_KEYS; i++)
          if (hit_vec[i]) tbl_vld[i] <= 1'b0;
        held_num <= held_num - HW'(1);
      end
    end
  end

  assign any_held = (held_num != '0);

  ps2_ev_fifo #(.W(10), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk      (clk),
    .clrn     (clrn),
    .push     (push),
    .push_dat ({in_code, is_ext, fire_brk}),
    .pop      (ev_ready),
    .vld      (ev_valid),
    .drop     (drop),
    .head     (head)
  );

  assign ev_code  = head[9:2];
  assign ev_ext   = head[1];
  assign ev_break = head[0];
endmodule

// File: tb/tb_ps2_key_event.sv
// Scoreboard bench for ps2_key_event: expected events queued by stimulus, popped by a negedge monitor.
module tb_ps2_key_event;
  logic       clk = 1'b0, clrn = 1'b0, in_valid = 1'b0, ev_ready = 1'b0, clr_flags = 1'b0;
  logic [7:0] in_code = 8'h00;
  logic       ev_valid, ev_ext, ev_break, any_held, overflow, proto_err;
  logic [7:0] ev_code, key_count;
  logic [2:0] held_num;

  int         n_chk = 0, n_pass = 0;
  logic [9:0] exp_q [$];

  ps2_key_event #(.CNT_W(8), .FIFO_DEPTH(4), .MAX_KEYS(4)) dut (
    .clk(clk), .clrn(clrn), .in_valid(in_valid), .in_code(in_code),
    .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_code(ev_code), .ev_ext(ev_ext),
    .ev_break(ev_break), .key_count(key_count), .held_num(held_num), .any_held(any_held),
    .overflow(overflow), .proto_err(proto_err), .clr_flags(clr_flags)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Monitor: every accepted head must match the oldest expected event.
  always @(negedge clk) begin
    logic [9:0] e;
    if (clrn && ev_valid && ev_ready) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        $display("FAIL unexpected_event: got %0h expected none", {ev_code, ev_ext, ev_break});
      end else begin
        e = exp_q.pop_front();
        chk("event", {ev_code, ev_ext, ev_break}, e);
      end
    end
  end

  task automatic expect_ev(input logic [7:0] c, input logic e, input logic b);
    exp_q.push_back({c, e, b});
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [7:0] b);
    in_valid = 1'b1;
    in_code  = b;
    tick(1);
    in_valid = 1'b0;
  endtask

  task automatic drain;
    ev_ready = 1'b1;
    for (int i = 0; i < 200 && exp_q.size() != 0; i++) tick(1);
    tick(2);
    chk("drain_left", exp_q.size(), 0);
    chk("drain_ev_valid", ev_valid, 0);
  endtask

  // Reset with a byte presented during reset; it must leave no trace.
  task automatic do_reset;
    in_valid = 1'b1;
    in_code  = 8'h1C;
    clrn     = 1'b0;
    #2;
    chk("rst_ev_valid", ev_valid, 0);
    chk("rst_key_count", key_count, 0);
    chk("rst_held_num", held_num, 0);
    chk("rst_any_held", any_held, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_proto_err", proto_err, 0);
    tick(1);
    in_valid = 1'b0;
    clrn     = 1'b1;
    tick(1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    tick(1);
    do_reset();

    // Single make/break.
    ev_ready = 1'b1;
    expect_ev(8'h1C, 0, 0);
    expect_ev(8'h1C, 0, 1);
    send(8'h1C);
    chk("p1_held", held_num, 1);
    chk("p1_any_held", any_held, 1);
    chk("p1_count", key_count, 1);
    send(8'hF0);
    send(8'h1C);
    chk("p1_held_after", held_num, 0);
    chk("p1_count_after", key_count, 1);
    drain();

    // Extended key with typematic repeats.
    do_reset();
    expect_ev(8'h75, 1, 0);
    expect_ev(8'h75, 1, 1);
    send(8'hE0); send(8'h75);
    send(8'hE0); send(8'h75);
    send(8'hE0); send(8'h75);
    chk("p2_held_mid", held_num, 1);
    send(8'hE0); send(8'hF0); send(8'h75);
    chk("p2_count", key_count, 1);
    chk("p2_held", held_num, 0);
    drain();

    // FIFO overflow with a stalled consumer and a full held table.
    do_reset();
    ev_ready = 1'b0;
    expect_ev(8'h15, 0, 0);
    expect_ev(8'h1D, 0, 0);
    expect_ev(8'h24, 0, 0);
    expect_ev(8'h2D, 0, 0);
    send(8'h15); send(8'h1D); send(8'h24); send(8'h2D);
    chk("p3_no_ovf_yet", overflow, 0);
    send(8'h2C);
    chk("p3_overflow", overflow, 1);
    chk("p3_count", key_count, 5);
    chk("p3_held", held_num, 4);
    drain();
    clr_flags = 1'b1;
    tick(1);
    clr_flags = 1'b0;
    chk("p3_ovf_clr", overflow, 0);
    expect_ev(8'h2C, 0, 1);
    send(8'hF0); send(8'h2C);
    chk("p3_held_untracked_brk", held_num, 4);
    expect_ev(8'h15, 0, 1);
    send(8'hF0); send(8'h15);
    chk("p3_held_brk", held_num, 3);
    drain();

    // Push into a full FIFO while the head is popped in the same cycle.
    do_reset();
    ev_ready = 1'b0;
    expect_ev(8'h15, 0, 0);
    expect_ev(8'h1D, 0, 0);
    expect_ev(8'h24, 0, 0);
    expect_ev(8'h2D, 0, 0);
    expect_ev(8'h2C, 0, 0);
    send(8'h15); send(8'h1D); send(8'h24); send(8'h2D);
    ev_ready = 1'b1;
    send(8'h2C);
    chk("p4_no_overflow", overflow, 0);
    drain();

    // Protocol errors, ignored bytes and set-wins on clear.
    send(8'hF0); send(8'hF0);
    chk("p5_proto_err", proto_err, 1);
    chk("p5_no_event", ev_valid, 0);
    expect_ev(8'h1C, 0, 0);
    send(8'h1C);
    drain();
    clr_flags = 1'b1;
    tick(1);
    clr_flags = 1'b0;
    chk("p5_perr_clr", proto_err, 0);
    expect_ev(8'h22, 0, 0);
    send(8'hE0); send(8'hE1); send(8'h22);
    chk("p5_ignored_no_err", proto_err, 0);
    drain();
    send(8'hE0);
    clr_flags = 1'b1;
    send(8'hE0);
    clr_flags = 1'b0;
    chk("p5_set_wins", proto_err, 1);

    // Press counter wrap over 256 distinct make/break pairs.
    do_reset();
    ev_ready = 1'b1;
    for (int i = 0; i < 256; i++) begin
      logic [7:0] c;
      logic       e;
      c = 8'((i % 200) + 1);
      e = (i >= 200);
      expect_ev(c, e, 0);
      expect_ev(c, e, 1);
      if (e) send(8'hE0);
      send(c);
      if (e) send(8'hE0);
      send(8'hF0);
      send(c);
      if (i == 254) chk("p6_count_255", key_count, 255);
    end
    chk("p6_count_wrap", key_count, 0);
    chk("p6_held", held_num, 0);
    drain();

    // Reset after a lone E0 discards the prefix.
    send(8'hE0);
    clrn = 1'b0;
    tick(1);
    clrn = 1'b1;
    tick(1);
    expect_ev(8'h1C, 0, 0);
    send(8'h1C);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
